axi_c_output_writer: RTL and testbench
======================================

Name: axi_c_output_writer

Overview:
- AXI4 write-channel initiator that stores one systolic-array output diagonal into the C result matrix in memory.
- The C matrix is 8x8 bytes, row-major, 8 bytes per row (two 32-bit words per row).
- On each start, the block takes a 64-bit flat word holding one byte per row. For computation cycle c, it writes byte C[i][c-i] for every valid row i, using single-beat, byte-strobed writes.
- It is the write-side counterpart of the A-matrix read extractor. It connects to the same memory block wrapper, on its write port.

Parameters:
- BASE_ADDR, 12'd0, byte base address of the C matrix in memory.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- cycle  in  4  computation cycle index; 0..14 valid
- c_flat_in  in  64  row i's byte in bits [i*8+:8]
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  set if any write response was not OKAY; held until the next accepted start
- m_axi_awaddr  out  12  word-aligned write address
- m_axi_awsize  out  3  constant 3'b010 (4 bytes)
- m_axi_awlen  out  8  constant 0 (single beat)
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awcache  out  4  constant 0
- m_axi_awlock  out  1  constant 0
- m_axi_awprot  out  3  constant 0
- m_axi_awvalid  out  1  address valid
- m_axi_awready  in  1  address ready
- m_axi_wdata  out  32  write data
- m_axi_wstrb  out  4  one-hot byte strobe
- m_axi_wlast  out  1  equals m_axi_wvalid
- m_axi_wvalid  out  1  data valid
- m_axi_wready  in  1  data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  response valid
- m_axi_bready  out  1  response ready

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State returns to IDLE.
  - busy, done, err, awvalid, wvalid and bready are all 0; awaddr, wdata and wstrb are 0.
  - Reset overrides any in-flight transaction; no further AXI activity follows it.
- Row range:
  - c<=7: start_i=0, end_i=c.
  - 8<=c<=14: start_i=c-7, end_i=7.
  - Column j=c-i, 4-bit.
- Address and data for row i:
  - awaddr = BASE_ADDR + i*8 + (j>=4 ? 4 : 0).
  - Byte lane L = j[1:0].
  - wstrb = 1<<L.
  - wdata = byte i placed in lane L; all other lanes are 0.
- IDLE:
  - When start=1, latch cycle and c_flat_in, clear err, set i=start_i, set busy=1, and go to ISSUE.
  - If cycle=15: make no AXI transfers, set err=1, and go to DONE.
- ISSUE (entered at cycle T):
  - At T, register awaddr, wdata and wstrb, and set awvalid=1 and wvalid=1.
  - Each valid stays high, with stable address/data, until its own ready is sampled high; it then drops independently.
  - The AW and W handshakes may complete in either order or in the same cycle. awvalid never depends on wready, and wvalid never depends on awready.
  - When both handshakes are complete, go to RESP.
- RESP:
  - bready=1.
  - On bvalid=1: if bresp!=2'b00, set err=1; drop bready.
  - If i<end_i: i=i+1, go to ISSUE.
  - Otherwise go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy drops in the same cycle; go to IDLE.
- Writes are issued strictly one at a time, in row order start_i..end_i. There is never more than one outstanding transaction.
- A start pulse while busy is ignored. Latched inputs do not change mid-operation.
- Minimum time per row with zero-wait-state slave: ISSUE 1 cycle + RESP 1 cycle.
- A bvalid arriving in the same cycle as the last AW/W handshake is not accepted until RESP.

Test Plan:
- cycle=0, c_flat_in=64'h00000000000000AB -> one write: awaddr=0x000, wdata=0x000000AB, wstrb=4'b0001; done pulses once; err=0.
- cycle=7, byte i = 0x10+i -> 8 writes in order:
  - row 0: addr 0x004, strb 1000, wdata 0x10000000.
  - row 3: addr 0x01C, strb 0001, wdata 0x00000013.
  - row 4: addr 0x020, strb 1000.
  - row 7: addr 0x038, strb 0001, wdata 0x00000017.
- cycle=14, c_flat_in=64'hCD00000000000000 -> a single write: addr 0x03C, strb 1000, wdata 0xCD000000; BASE_ADDR=12'h100 shifts the address to 0x13C.
- Backpressure: awready held low 3 cycles, wready high immediately -> wvalid high 1 cycle, awvalid high 4 cycles with stable awaddr; bready is not asserted before both handshakes complete.
- cycle=9 with bresp=2'b10 on the second write -> all 6 rows (2..7) are still written; err=1 at done and holds through IDLE; the next start clears err.
- rst asserted during RESP of row 3 -> the next cycle shows awvalid=wvalid=bready=busy=0; a start issued during busy is ignored; cycle=15 -> no AW transfer, done=1, err=1.

Source files
------------

// File: rtl/axi_c_output_writer.sv
// Writes one systolic-array output diagonal into the 8x8 byte C matrix over AXI4.
// Each row is one single-beat, byte-strobed write, and only one is outstanding at a time.
module axi_c_output_writer #(
    parameter logic [11:0] BASE_ADDR = 12'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  cycle,
    input  logic [63:0] c_flat_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awsize,
    output logic [7:0]  m_axi_awlen,
    output logic [1:0]  m_axi_awburst,
    output logic [3:0]  m_axi_awcache,
    output logic        m_axi_awlock,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);
    // state | meaning
    // IDLE  | waiting for start
    // ISSUE | AW and W valids up until each handshakes
    // RESP  | bready up, waiting for the write response
    // DONE  | one-cycle done pulse
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_DONE} state_t;

    state_t      state_q;
    logic [3:0]  cyc_q;
    logic [63:0] flat_q;
    logic [2:0]  row_q, end_q;
    logic        busy_q, done_q, err_q;
    logic        awvalid_q, wvalid_q, bready_q;
    logic [11:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [3:0]  cyc_sel, col_d;
    logic [63:0] flat_sel;
    logic [2:0]  first_row_d, last_row_d, row_d;
    logic [1:0]  lane_d;
    logic [7:0]  byte_d;
    logic [11:0] awaddr_d;
    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;
    logic        aw_done, w_done;

    // The beat being loaded is the first row when leaving IDLE, otherwise the next row.
    always_comb begin
        cyc_sel  = (state_q == S_IDLE) ? cycle : cyc_q;
        flat_sel = (state_q == S_IDLE) ? c_flat_in : flat_q;
        if (cyc_sel <= 4'd7) begin
            first_row_d = 3'd0;
            last_row_d  = cyc_sel[2:0];
        end else begin
            first_row_d = cyc_sel[2:0] + 3'd1;
            last_row_d  = 3'd7;
        end
        row_d    = (state_q == S_IDLE) ? first_row_d : row_q + 3'd1;
        col_d    = cyc_sel - {1'b0, row_d};
        lane_d   = col_d[1:0];
        byte_d   = flat_sel[{row_d, 3'b000} +: 8];
        awaddr_d = BASE_ADDR + {6'd0, row_d, 3'd0} + ((col_d >= 4'd4) ? 12'd4 : 12'd0);
        wstrb_d  = 4'b0001 << lane_d;
        wdata_d  = {24'd0, byte_d} << {lane_d, 3'b000};
        aw_done  = !awvalid_q || m_axi_awready;
        w_done   = !wvalid_q || m_axi_wready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= 4'd0;
            flat_q    <= 64'd0;
            row_q     <= 3'd0;
            end_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= 12'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cyc_q  <= cycle;
                        flat_q <= c_flat_in;
                        err_q  <= 1'b0;
                        if (cycle == 4'd15) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            row_q     <= first_row_d;
                            end_q     <= last_row_d;
                            busy_q    <= 1'b1;
                            awaddr_q  <= awaddr_d;
                            wdata_q   <= wdata_d;
                            wstrb_q   <= wstrb_d;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi_wready) wvalid_q <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (m_axi_bvalid && bready_q) begin
                        bready_q <= 1'b0;
                        if (m_axi_bresp != 2'b00) err_q <= 1'b1;
                        if (row_q < end_q) begin
                            row_q     <= row_q + 3'd1;
                            awaddr_q  <= awaddr_d;
                            wdata_q   <= wdata_d;
                            wstrb_q   <= wstrb_d;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_ISSUE;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = wvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
endmodule

// File: tb/tb_axi_c_output_writer.sv
// Scoreboard bench for axi_c_output_writer: directed diagonals against a stallable AXI slave,
// plus a second instance with a non-zero base address.
module tb_axi_c_output_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cycle = 4'd0;
    logic [63:0] c_flat_in = 64'd0;
    logic        busy, done, err;
    logic [11:0] awaddr;
    logic [2:0]  awsize, awprot;
    logic [7:0]  awlen;
    logic [1:0]  awburst, bresp;
    logic [3:0]  awcache, wstrb;
    logic        awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [31:0] wdata;

    logic        start2 = 1'b0;
    logic [3:0]  cycle2 = 4'd0;
    logic [63:0] flat2 = 64'd0;
    logic        busy2, done2, err2;
    logic [11:0] awaddr2;
    logic [2:0]  awsize2, awprot2;
    logic [7:0]  awlen2;
    logic [1:0]  awburst2;
    logic [3:0]  awcache2, wstrb2;
    logic        awlock2, awvalid2, wlast2, wvalid2, bready2, bvalid2;
    logic [31:0] wdata2;
    logic        awready2 = 1'b1;
    logic        wready2 = 1'b1;
    logic [1:0]  bresp2 = 2'b00;
    assign bvalid2 = bready2;

    always #5 clk = ~clk;

    axi_c_output_writer dut (
        .clk(clk), .rst(rst), .start(start), .cycle(cycle), .c_flat_in(c_flat_in),
        .busy(busy), .done(done), .err(err),
        .m_axi_awaddr(awaddr), .m_axi_awsize(awsize), .m_axi_awlen(awlen),
        .m_axi_awburst(awburst), .m_axi_awcache(awcache), .m_axi_awlock(awlock),
        .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    axi_c_output_writer #(.BASE_ADDR(12'h100)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .cycle(cycle2), .c_flat_in(flat2),
        .busy(busy2), .done(done2), .err(err2),
        .m_axi_awaddr(awaddr2), .m_axi_awsize(awsize2), .m_axi_awlen(awlen2),
        .m_axi_awburst(awburst2), .m_axi_awcache(awcache2), .m_axi_awlock(awlock2),
        .m_axi_awprot(awprot2), .m_axi_awvalid(awvalid2), .m_axi_awready(awready2),
        .m_axi_wdata(wdata2), .m_axi_wstrb(wstrb2), .m_axi_wlast(wlast2),
        .m_axi_wvalid(wvalid2), .m_axi_wready(wready2),
        .m_axi_bresp(bresp2), .m_axi_bvalid(bvalid2), .m_axi_bready(bready2)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [11:0] exp_aw[$];
    logic [35:0] exp_w[$];
    bit          exp_done[$];
    int hs_aw = 0, hs_w = 0, hs_b = 0, done_cnt = 0, aw_hi = 0, w_hi = 0;
    int aw_stall = 0, w_stall = 0, err_idx = -1, b_block_at = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic push(input logic [11:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_aw.push_back(a);
        exp_w.push_back({s, d});
    endtask

    // Slave: ready after a programmable stall, response only once bready is seen.
    initial begin
        int awc, wc;
        awc = 0; wc = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (awvalid) begin
                if (awc < aw_stall) begin awready = 1'b0; awc++; end
                else awready = 1'b1;
            end else begin awready = 1'b0; awc = 0; end
            if (wvalid) begin
                if (wc < w_stall) begin wready = 1'b0; wc++; end
                else wready = 1'b1;
            end else begin wready = 1'b0; wc = 0; end
            if (bready && hs_b != b_block_at) begin
                bvalid = 1'b1;
                bresp  = (hs_b == err_idx) ? 2'b10 : 2'b00;
            end else begin
                bvalid = 1'b0;
                bresp  = 2'b00;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a handshake or pulses done.
    always @(negedge clk) begin
        logic [11:0] ea;
        logic [35:0] ew;
        bit          ed;
        if (!rst) begin
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (awvalid && !awready && exp_aw.size() > 0) check("awaddr_stable", awaddr, exp_aw[0]);
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) check("aw_unexpected", awaddr, 64'hFFFF);
                else begin ea = exp_aw.pop_front(); check("awaddr", awaddr, ea); end
                hs_aw++;
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) check("w_unexpected", {wstrb, wdata}, 64'hF_FFFF_FFFF);
                else begin ew = exp_w.pop_front(); check("wlast_wstrb_wdata", {wlast, wstrb, wdata}, {1'b1, ew}); end
                hs_w++;
            end
            if (bvalid && bready) begin
                check("b_after_aw_and_w", {hs_aw == hs_b + 1, hs_w == hs_b + 1}, 2'b11);
                hs_b++;
            end
            if (done) begin
                check("busy_low_at_done", busy, 1'b0);
                if (exp_done.size() == 0) check("done_unexpected", done, 1'b0);
                else begin ed = exp_done.pop_front(); check("err_at_done", err, ed); end
                done_cnt++;
            end
        end
    end

    task automatic run_op(input logic [3:0] cyc, input logic [63:0] flat, input int poke);
        int  d0;
        bit  seen;
        hs_aw = 0; hs_w = 0; hs_b = 0; aw_hi = 0; w_hi = 0;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; cycle = cyc; c_flat_in = flat;
        @(posedge clk); #1;
        start = 1'b0; cycle = cyc ^ 4'h5; c_flat_in = ~flat;
        @(negedge clk);
        if (cyc != 4'd15) begin
            check("busy_after_start", busy, 1'b1);
            check("err_cleared_on_start", err, 1'b0);
        end else begin
            check("busy_bad_cycle", busy, 1'b0);
        end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (done_cnt != d0) seen = 1'b1;
            else begin
                start = (poke >= 0 && k == poke);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1'b1);
        check("queues_drained", exp_aw.size() + exp_w.size() + exp_done.size(), 0);
    endtask

    initial begin
        bit reached;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {busy, done, err, awvalid, wvalid, bready, awaddr, wdata, wstrb}, 0);
        check("axi_constants", {awsize, awlen, awburst, awcache, awlock, awprot, wlast},
              {3'b010, 8'd0, 2'b01, 4'd0, 1'b0, 3'd0, 1'b0});

        // cycle 0: single write of row 0
        push(12'h000, 4'b0001, 32'h000000AB);
        exp_done.push_back(1'b0);
        run_op(4'd0, 64'h00000000000000AB, -1);

        // cycle 7: full diagonal, with a start poke while busy
        push(12'h004, 4'b1000, 32'h10000000);
        push(12'h00C, 4'b0100, 32'h00110000);
        push(12'h014, 4'b0010, 32'h00001200);
        push(12'h01C, 4'b0001, 32'h00000013);
        push(12'h020, 4'b1000, 32'h14000000);
        push(12'h028, 4'b0100, 32'h00150000);
        push(12'h030, 4'b0010, 32'h00001600);
        push(12'h038, 4'b0001, 32'h00000017);
        exp_done.push_back(1'b0);
        run_op(4'd7, 64'h1716151413121110, 3);

        // cycle 14: only row 7
        push(12'h03C, 4'b1000, 32'hCD000000);
        exp_done.push_back(1'b0);
        run_op(4'd14, 64'hCD00000000000000, -1);

        // AW backpressure
        aw_stall = 3;
        push(12'h000, 4'b0001, 32'h0000005E);
        exp_done.push_back(1'b0);
        run_op(4'd0, 64'h000000000000005E, -1);
        check("awvalid_cycles_stalled", aw_hi, 4);
        check("wvalid_cycles_stalled", w_hi, 1);
        aw_stall = 0;

        // W backpressure: AW completes first
        w_stall = 2;
        push(12'h000, 4'b0010, 32'h00003C00);
        push(12'h008, 4'b0001, 32'h0000005A);
        exp_done.push_back(1'b0);
        run_op(4'd1, 64'h0000000000005A3C, -1);
        check("awvalid_cycles_wstall", aw_hi, 2);
        check("wvalid_cycles_wstall", w_hi, 6);
        w_stall = 0;

        // cycle 9 with SLVERR on the second response
        err_idx = 1;
        push(12'h014, 4'b1000, 32'h33000000);
        push(12'h01C, 4'b0100, 32'h00440000);
        push(12'h024, 4'b0010, 32'h00005500);
        push(12'h02C, 4'b0001, 32'h00000066);
        push(12'h030, 4'b1000, 32'h77000000);
        push(12'h038, 4'b0100, 32'h00880000);
        exp_done.push_back(1'b1);
        run_op(4'd9, 64'h8877665544332211, -1);
        check("rows_after_err", hs_b, 6);
        err_idx = -1;
        repeat (3) @(negedge clk);
        check("err_held_in_idle", err, 1'b1);
        push(12'h000, 4'b0001, 32'h00000077);
        exp_done.push_back(1'b0);
        run_op(4'd0, 64'h0000000000000077, -1);

        // reset during RESP of row 3
        hs_aw = 0; hs_w = 0; hs_b = 0;
        b_block_at = 3;
        push(12'h004, 4'b1000, 32'h10000000);
        push(12'h00C, 4'b0100, 32'h00110000);
        push(12'h014, 4'b0010, 32'h00001200);
        push(12'h01C, 4'b0001, 32'h00000013);
        @(posedge clk); #1;
        start = 1'b1; cycle = 4'd7; c_flat_in = 64'h1716151413121110;
        @(posedge clk); #1;
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            @(negedge clk);
            if (bready && hs_b == 3) reached = 1'b1;
        end
        check("reached_resp_row3", reached, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("after_reset_idle", {awvalid, wvalid, bready, busy, done, err}, 6'd0);
        exp_aw.delete(); exp_w.delete(); exp_done.delete();
        b_block_at = -1;
        aw_hi = 0; w_hi = 0;
        repeat (6) @(negedge clk);
        check("no_axi_after_reset", aw_hi + w_hi, 0);

        // cycle 15: no transfer, error completion
        exp_done.push_back(1'b1);
        run_op(4'd15, 64'hFFFFFFFFFFFFFFFF, -1);
        check("no_aw_bad_cycle", aw_hi + w_hi, 0);

        // non-zero base address on the second instance
        @(posedge clk); #1;
        start2 = 1'b1; cycle2 = 4'd14; flat2 = 64'hCD00000000000000;
        @(posedge clk); #1;
        start2 = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 50 && !reached; k++) begin
            @(negedge clk);
            if (awvalid2) reached = 1'b1;
        end
        check("base_aw_seen", reached, 1'b1);
        check("base_awaddr", awaddr2, 12'h13C);
        check("base_wstrb_wdata", {wstrb2, wdata2}, {4'b1000, 32'hCD000000});
        reached = 1'b0;
        for (int k = 0; k < 50 && !reached; k++) begin
            @(negedge clk);
            if (done2) reached = 1'b1;
        end
        check("base_done_err", {reached, err2}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
